// File: rtl/cw305_usb_pkg.sv
// Shared types and timing limits for the CW305 USB register-bus master.
package cw305_usb_pkg;

    localparam int TIMER_W    = 4;
    localparam int TIMING_MIN = 1;
    localparam int TIMING_MAX = 15;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        STROBE = 2'd2,
        HOLD   = 2'd3
    } bus_state_e;

endpackage

// File: rtl/cw305_sat_counter.sv
// Saturating up-counter used for the optional transfer statistics.
module cw305_sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             srst,
    input  logic             inc_i,
    output logic [WIDTH-1:0] count_o
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (inc_i && (count_q != {WIDTH{1'b1}})) begin
            count_d = count_q + WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/cw305_usb_bus_master.sv
// Initiator for the CW305 8-bit USB register bus: one command -> one timed bus cycle.
// Optional transfer counters are enabled by defining USB_MASTER_STATS_EN.
module cw305_usb_bus_master
    import cw305_usb_pkg::*;
#(
    parameter int pADDR_WIDTH = 21,
    parameter int pSETUP      = 1,
    parameter int pSTROBE     = 2,
    parameter int pHOLD       = 1
) (
    input  logic                   usb_clk,
    input  logic                   rst,
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic                   cmd_write,
    input  logic [pADDR_WIDTH-1:0] cmd_addr,
    input  logic [7:0]             cmd_wdata,
    output logic                   rsp_valid,
    output logic                   rsp_write,
    output logic [7:0]             rsp_rdata,
    output logic [pADDR_WIDTH-1:0] usb_addr,
    output logic [7:0]             usb_dout,
    output logic                   usb_data_oe,
    input  logic [7:0]             usb_din,
    output logic                   usb_cen,
    output logic                   usb_rdn,
    output logic                   usb_wrn
`ifdef USB_MASTER_STATS_EN
    ,
    output logic [15:0]            stat_wr_cnt,
    output logic [15:0]            stat_rd_cnt
`endif
);

    if (pSETUP < TIMING_MIN || pSETUP > TIMING_MAX) begin : g_bad_setup
        $error("cw305_usb_bus_master: pSETUP out of range 1..15");
    end
    if (pSTROBE < TIMING_MIN || pSTROBE > TIMING_MAX) begin : g_bad_strobe
        $error("cw305_usb_bus_master: pSTROBE out of range 1..15");
    end
    if (pHOLD < TIMING_MIN || pHOLD > TIMING_MAX) begin : g_bad_hold
        $error("cw305_usb_bus_master: pHOLD out of range 1..15");
    end

    // The phase timer counts down to zero, so each phase loads (cycles - 1).
    localparam logic [TIMER_W-1:0] SETUP_LOAD  = TIMER_W'(pSETUP - 1);
    localparam logic [TIMER_W-1:0] STROBE_LOAD = TIMER_W'(pSTROBE - 1);
    localparam logic [TIMER_W-1:0] HOLD_LOAD   = TIMER_W'(pHOLD - 1);

    bus_state_e             state_q;
    logic [TIMER_W-1:0]     timer_q;
    logic                   write_q;
    logic                   cmd_ready_q;
    logic                   rsp_valid_q;
    logic                   rsp_write_q;
    logic [7:0]             rsp_rdata_q;
    logic [pADDR_WIDTH-1:0] addr_q;
    logic [7:0]             dout_q;
    logic                   oe_q;
    logic                   cen_q;
    logic                   rdn_q;
    logic                   wrn_q;

    always_ff @(posedge usb_clk) begin
        if (rst) begin
            state_q     <= IDLE;
            timer_q     <= '0;
            write_q     <= 1'b0;
            cmd_ready_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_write_q <= 1'b0;
            rsp_rdata_q <= '0;
            addr_q      <= '0;
            dout_q      <= '0;
            oe_q        <= 1'b0;
            cen_q       <= 1'b1;
            rdn_q       <= 1'b1;
            wrn_q       <= 1'b1;
        end else begin
            rsp_valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    cmd_ready_q <= 1'b1;
                    if (cmd_valid && cmd_ready_q) begin
                        cmd_ready_q <= 1'b0;
                        write_q     <= cmd_write;
                        addr_q      <= cmd_addr;
                        cen_q       <= 1'b0;
                        if (cmd_write) begin
                            dout_q <= cmd_wdata;
                            oe_q   <= 1'b1;
                        end
                        timer_q <= SETUP_LOAD;
                        state_q <= SETUP;
                    end
                end
                SETUP: begin
                    if (timer_q == '0) begin
                        rdn_q   <= write_q;
                        wrn_q   <= ~write_q;
                        timer_q <= STROBE_LOAD;
                        state_q <= STROBE;
                    end else begin
                        timer_q <= timer_q - TIMER_W'(1);
                    end
                end
                STROBE: begin
                    if (timer_q == '0) begin
                        // Sample on the edge that ends the strobe, while the target still drives.
                        if (!write_q) begin
                            rsp_rdata_q <= usb_din;
                        end
                        rdn_q   <= 1'b1;
                        wrn_q   <= 1'b1;
                        timer_q <= HOLD_LOAD;
                        state_q <= HOLD;
                    end else begin
                        timer_q <= timer_q - TIMER_W'(1);
                    end
                end
                HOLD: begin
                    if (timer_q == '0) begin
                        cen_q       <= 1'b1;
                        oe_q        <= 1'b0;
                        rsp_valid_q <= 1'b1;
                        rsp_write_q <= write_q;
                        cmd_ready_q <= 1'b1;
                        state_q     <= IDLE;
                    end else begin
                        timer_q <= timer_q - TIMER_W'(1);
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign cmd_ready   = cmd_ready_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_write   = rsp_write_q;
    assign rsp_rdata   = rsp_rdata_q;
    assign usb_addr    = addr_q;
    assign usb_dout    = dout_q;
    assign usb_data_oe = oe_q;
    assign usb_cen     = cen_q;
    assign usb_rdn     = rdn_q;
    assign usb_wrn     = wrn_q;

`ifdef USB_MASTER_STATS_EN
    cw305_sat_counter #(.WIDTH(16)) u_stat_wr (
        .clk     (usb_clk),
        .srst    (rst),
        .inc_i   (rsp_valid_q && rsp_write_q),
        .count_o (stat_wr_cnt)
    );

    cw305_sat_counter #(.WIDTH(16)) u_stat_rd (
        .clk     (usb_clk),
        .srst    (rst),
        .inc_i   (rsp_valid_q && !rsp_write_q),
        .count_o (stat_rd_cnt)
    );
`endif

endmodule
